// File: rtl/tpu_mac_engine.sv
// tpu_mac_engine: byte-stream N x N matrix multiply / multiply-accumulate.
// Loads A then B as little-endian, row-major elements over an 8-bit valid/ready
// input. Computes C = A*B or C += A*B with one saturating MAC per cycle, in
// i, j, k loop order. Streams C out as zero-extended, little-endian OB-byte
// elements over an 8-bit valid/ready output.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, accumulate   begin a load/compute run; accumulate selects C += A*B
//   clear               zero C and ovf
//   read_start          stream C out
//   in_data/in_valid/in_ready     input byte stream (ready only while loading)
//   out_data/out_valid/out_ready  output byte stream
//   busy, done, ovf     not idle, compute-finished pulse, sticky saturation flag
module tpu_mac_engine #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       accumulate,
    input  logic       clear,
    input  logic       read_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       ovf
);
    localparam int unsigned BPE = DW / 8;
    localparam int unsigned OB  = (AW + 7) / 8;
    localparam int unsigned NE  = N * N;
    localparam int unsigned EW  = $clog2(NE);
    localparam int unsigned IW  = $clog2(N);
    localparam int unsigned BW  = $clog2(OB);
    localparam int unsigned PW  = 2 * DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   a_q [NE];
    logic [DW-1:0]   a_d [NE];
    logic [DW-1:0]   b_q [NE];
    logic [DW-1:0]   b_d [NE];
    logic [AW-1:0]   c_q [NE];
    logic [AW-1:0]   c_d [NE];
    logic [EW-1:0]   elem_q, elem_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic            mode_acc_q, mode_acc_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic            in_fire, out_fire, load_last, out_last;
    logic [EW-1:0]   a_idx, b_idx, c_idx, nxt_elem;
    logic [BW-1:0]   nxt_byte;
    logic [PW-1:0]   prod;
    logic [AW:0]     sum;
    logic [DW-1:0]   byte_mask, byte_val;
    logic [BW+2:0]   byte_sh;

    // Selects byte b of a C element zero-extended to OB bytes.
    function automatic logic [7:0] c_byte(input logic [AW-1:0] c, input logic [BW-1:0] b);
        logic [OB*8-1:0] ext;
        ext = (OB*8)'(c);
        return ext[{b, 3'b000} +: 8];
    endfunction

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid_q & out_ready;
    assign load_last = (elem_q == EW'(NE - 1)) && (byte_q == BW'(BPE - 1));
    assign out_last  = (elem_q == EW'(NE - 1)) && (byte_q == BW'(OB - 1));

    // Datapath for one MAC step and byte insertion.
    assign a_idx     = EW'(i_q * N + k_q);
    assign b_idx     = EW'(k_q * N + j_q);
    assign c_idx     = EW'(i_q * N + j_q);
    assign prod      = PW'(a_q[a_idx]) * PW'(b_q[b_idx]);
    assign sum       = (AW+1)'(c_q[c_idx]) + (AW+1)'(prod);
    assign byte_sh   = {byte_q, 3'b000};
    assign byte_mask = DW'(8'hFF) << byte_sh;
    assign byte_val  = DW'(in_data) << byte_sh;
    assign nxt_elem  = (byte_q == BW'(OB - 1)) ? elem_q + EW'(1) : elem_q;
    assign nxt_byte  = (byte_q == BW'(OB - 1)) ? '0 : byte_q + BW'(1);

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        elem_d     = elem_q;
        byte_d     = byte_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        mode_acc_d = mode_acc_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    for (int e = 0; e < NE; e++) c_d[e] = '0;
                    ovf_d = 1'b0;
                end else if (start) begin
                    mode_acc_d = accumulate;
                    elem_d     = '0;
                    byte_d     = '0;
                    state_d    = S_LOAD_A;
                end else if (read_start) begin
                    elem_d     = '0;
                    byte_d     = '0;
                    out_data_d = c_byte(c_q[0], '0);
                    state_d    = S_OUTPUT;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (in_fire) begin
                    if (state_q == S_LOAD_A)
                        a_d[elem_q] = (a_q[elem_q] & ~byte_mask) | byte_val;
                    else
                        b_d[elem_q] = (b_q[elem_q] & ~byte_mask) | byte_val;
                    if (load_last) begin
                        elem_d = '0;
                        byte_d = '0;
                        if (state_q == S_LOAD_A) begin
                            state_d = S_LOAD_B;
                        end else begin
                            i_d     = '0;
                            j_d     = '0;
                            k_d     = '0;
                            state_d = S_COMPUTE;
                        end
                    end else if (byte_q == BW'(BPE - 1)) begin
                        byte_d = '0;
                        elem_d = elem_q + EW'(1);
                    end else begin
                        byte_d = byte_q + BW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                // First k term overwrites C unless accumulating into prior result.
                if (k_q == '0 && !mode_acc_q) begin
                    c_d[c_idx] = AW'(prod);
                end else if (sum[AW]) begin
                    c_d[c_idx] = '1;
                    ovf_d      = 1'b1;
                end else begin
                    c_d[c_idx] = sum[AW-1:0];
                end
                if (k_q == IW'(N - 1)) begin
                    k_d = '0;
                    if (j_q == IW'(N - 1)) begin
                        j_d = '0;
                        if (i_q == IW'(N - 1)) begin
                            i_d     = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            S_OUTPUT: begin
                if (out_fire) begin
                    if (out_last) begin
                        elem_d     = '0;
                        byte_d     = '0;
                        out_data_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        elem_d     = nxt_elem;
                        byte_d     = nxt_byte;
                        out_data_d = c_byte(c_q[nxt_elem], nxt_byte);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake and status flags follow the state being entered.
        in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        out_valid_d = (state_d == S_OUTPUT);
        busy_d      = (state_d != S_IDLE);
    end

    // State and data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int e = 0; e < NE; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                c_q[e] <= '0;
            end
            elem_q      <= '0;
            byte_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            mode_acc_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            elem_q      <= elem_d;
            byte_q      <= byte_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            mode_acc_q  <= mode_acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_tpu_mac_engine.sv
// Scoreboard bench for tpu_mac_engine: a matrix-level reference model predicts
// C and ovf; expected output bytes are queued when a read is issued and a
// monitor pops and compares them as the DUT hands them over.
`timescale 1ns/1ps
module tb_tpu_mac_engine;
    localparam int unsigned N   = 2;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 20;
    localparam int unsigned BPE = DW / 8;
    localparam int unsigned OB  = (AW + 7) / 8;
    localparam int unsigned NE  = N * N;
    localparam longint      MAXC = (longint'(1) << AW) - 1;

    logic       clk = 1'b0;
    logic       rst, start, accumulate, clear, read_start;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic       busy, done, ovf;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    longint     ma[NE], mb[NE], mc[NE];
    bit         movf;
    longint     t1a[NE], t1b[NE], ffm[NE], ra[NE], rb[NE];

    tpu_mac_engine #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .clear(clear), .read_start(read_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-matrix product, saturated once at the end (equivalent
    // to per-step saturation because every term is non-negative).
    task automatic model_run(input bit acc);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s;
                s = acc ? mc[i*N+j] : longint'(0);
                for (int k = 0; k < N; k++) s += ma[i*N+k] * mb[k*N+j];
                if (s > MAXC) begin
                    s    = MAXC;
                    movf = 1'b1;
                end
                mc[i*N+j] = s;
            end
        end
    endtask

    task automatic model_zero();
        for (int e = 0; e < NE; e++) mc[e] = 0;
        movf = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on every accepted byte and checks
    // that a stalled byte is held stable.
    initial begin
        logic [7:0] held;
        logic [7:0] expb;
        bit         stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (stalled) chk("out_hold", longint'(out_data), longint'(held));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("out_extra_byte", longint'(1), longint'(0));
                    end else begin
                        expb = exp_q.pop_front();
                        chk("out_byte", longint'(out_data), longint'(expb));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send(input longint m[NE], input bit gaps, input int nbytes);
        int  cnt;
        int  guard;
        bit  acc;
        cnt = 0;
        for (int e = 0; e < NE; e++) begin
            for (int b = 0; b < BPE; b++) begin
                if (cnt < nbytes) begin
                    if (gaps) begin
                        in_valid = 1'b0;
                        in_data  = 8'($urandom);
                        repeat ($urandom_range(0, 2)) tick();
                    end
                    in_valid = 1'b1;
                    in_data  = 8'(m[e] >> (8 * b));
                    guard    = 0;
                    acc      = 1'b0;
                    while (!acc && guard < 50) begin
                        @(negedge clk);
                        acc = in_ready;
                        tick();
                        guard++;
                    end
                    if (!acc) chk("in_accept_timeout", longint'(0), longint'(1));
                    cnt++;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run(input longint a[NE], input longint b[NE], input bit acc,
                       input bit gaps, input bit poke);
        int n;
        bit got, busy_ok;
        ma = a;
        mb = b;
        start = 1'b1;
        accumulate = acc;
        tick();
        start = 1'b0;
        accumulate = 1'b0;
        send(a, gaps, NE * BPE);
        send(b, gaps, NE * BPE);
        n = 0;
        got = 1'b0;
        busy_ok = 1'b1;
        while (!got && n < 40) begin
            if (poke && n == 3) begin
                start = 1'b1;
                clear = 1'b1;
                read_start = 1'b1;
            end
            tick();
            start = 1'b0;
            clear = 1'b0;
            read_start = 1'b0;
            n++;
            if (done) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        chk("done_latency", longint'(n), longint'(N * N * N));
        chk("busy_during_compute", longint'(busy_ok), longint'(1));
        chk("busy_after_done", longint'(busy), longint'(0));
        tick();
        chk("done_pulse_width", longint'(done), longint'(0));
        model_run(acc);
        chk("ovf_after_run", longint'(ovf), longint'(movf));
    endtask

    task automatic read_c(input bit bp);
        int nb, guard;
        bit a;
        for (int e = 0; e < NE; e++)
            for (int b = 0; b < OB; b++) exp_q.push_back(8'(mc[e] >> (8 * b)));
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
        nb = 0;
        guard = 0;
        while (nb < NE * OB && guard < 400) begin
            if (bp && (nb % 2 == 1)) begin
                out_ready = 1'b0;
                repeat (3) tick();
            end
            out_ready = 1'b1;
            @(negedge clk);
            a = out_valid;
            tick();
            if (a) nb++;
            guard++;
        end
        out_ready = 1'b1;
        chk("read_byte_count", longint'(nb), longint'(NE * OB));
        chk("out_valid_after_read", longint'(out_valid), longint'(0));
        chk("busy_after_read", longint'(busy), longint'(0));
        chk("scoreboard_empty", longint'(exp_q.size()), longint'(0));
        exp_q.delete();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        chk("busy_after_clear", longint'(busy), longint'(0));
        chk("ovf_after_clear", longint'(ovf), longint'(0));
    endtask

    task automatic saturate9();
        run(ffm, ffm, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 7; r++) run(ffm, ffm, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; accumulate = 1'b0; clear = 1'b0;
        read_start = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        t1a = '{1, 2, 3, 4};
        t1b = '{5, 6, 7, 8};
        for (int e = 0; e < NE; e++) ffm[e] = (longint'(1) << DW) - 1;
        model_zero();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", longint'(in_ready), longint'(0));
        chk("rst_out_valid", longint'(out_valid), longint'(0));
        chk("rst_out_data", longint'(out_data), longint'(0));
        chk("rst_busy", longint'(busy), longint'(0));
        chk("rst_done", longint'(done), longint'(0));
        chk("rst_ovf", longint'(ovf), longint'(0));

        // Basic multiply, then accumulate on top of it.
        run(t1a, t1b, 1'b0, 1'b0, 1'b0);
        read_c(1'b0);
        run(t1a, t1b, 1'b1, 1'b0, 1'b0);
        read_c(1'b0);
        read_c(1'b0);

        // Backpressure on both streams.
        do_clear();
        run(t1a, t1b, 1'b0, 1'b1, 1'b0);
        read_c(1'b1);

        // Random matrices, random mode, random gaps.
        for (int r = 0; r < 5; r++) begin
            for (int e = 0; e < NE; e++) begin
                ra[e] = longint'($urandom_range(0, (1 << DW) - 1));
                rb[e] = longint'($urandom_range(0, (1 << DW) - 1));
            end
            run(ra, rb, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            read_c(1'($urandom_range(0, 1)));
        end

        // clear beats start and read_start; controls ignored during compute.
        clear = 1'b1; start = 1'b1; read_start = 1'b1; accumulate = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0; read_start = 1'b0; accumulate = 1'b0;
        model_zero();
        chk("prio_busy", longint'(busy), longint'(0));
        chk("prio_in_ready", longint'(in_ready), longint'(0));
        chk("prio_out_valid", longint'(out_valid), longint'(0));
        tick();
        chk("prio_busy_later", longint'(busy), longint'(0));
        read_c(1'b0);
        run(t1a, t1b, 1'b0, 1'b0, 1'b1);
        read_c(1'b0);

        // Saturation: eight runs stay just below the limit, the ninth clips.
        do_clear();
        saturate9();
        read_c(1'b0);
        run(ffm, ffm, 1'b1, 1'b0, 1'b0);
        chk("sat_ovf_set", longint'(ovf), longint'(1));
        read_c(1'b0);
        do_clear();
        read_c(1'b0);

        // Reset in the middle of loading B, with ovf previously set.
        saturate9();
        run(ffm, ffm, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send(t1a, 1'b0, NE * BPE);
        send(t1b, 1'b0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_zero();
        chk("midrst_in_ready", longint'(in_ready), longint'(0));
        chk("midrst_busy", longint'(busy), longint'(0));
        chk("midrst_ovf", longint'(ovf), longint'(0));
        read_c(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
